// File: rtl/uart_tx_serializer_if.sv
// FIFO read port between the TX FIFO and the UART serializer.
// The serializer (master) pops words; the FIFO (slave) presents empty flag and read data.
interface uart_tx_serializer_if #(
    parameter int data_wd = 8
);
    logic               fifo_empty;
    logic [data_wd-1:0] fifo_rd_data;
    logic               fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO word per frame and shifts it out as
// start + data (LSB first) + optional parity + stop, at a run-time bit period.
module uart_tx_serializer #(
    parameter int data_wd = 8,
    parameter int div_wd  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [div_wd-1:0]    baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    uart_tx_serializer_if.master fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int bit_cw = (data_wd > 1) ? $clog2(data_wd) : 1;
    localparam logic [bit_cw-1:0] last_bit = bit_cw'(data_wd - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t             state;
    logic [data_wd-1:0] shreg;
    logic [div_wd-1:0]  baud_cnt;
    logic [div_wd-1:0]  div_l;
    logic [bit_cw-1:0]  bit_cnt;
    logic               par_en_l;
    logic               par_bit;
    logic               bit_end;

    // div_l is never 0, so the last clock of a bit is always div_l-1
    assign bit_end = (baud_cnt == div_l - div_wd'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            tx              <= 1'b1;
            fifo.fifo_rd_en <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            shreg           <= '0;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            div_l           <= div_wd'(1);
            par_en_l        <= 1'b0;
            par_bit         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_en && !fifo.fifo_empty) begin
                        fifo.fifo_rd_en <= 1'b1;
                        busy            <= 1'b1;
                        state           <= FETCH;
                    end
                end
                FETCH: begin
                    fifo.fifo_rd_en <= 1'b0;
                    state           <= LOAD;
                end
                LOAD: begin
                    // Frame settings are frozen here so mid-frame input changes cannot tear a frame
                    shreg    <= fifo.fifo_rd_data;
                    div_l    <= (baud_div == '0) ? div_wd'(1) : baud_div;
                    par_en_l <= parity_en;
                    par_bit  <= parity_odd ? ~^fifo.fifo_rd_data : ^fifo.fifo_rd_data;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + div_wd'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == last_bit) begin
                            bit_cnt <= '0;
                            if (par_en_l) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + bit_cw'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + div_wd'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + div_wd'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + div_wd'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
